// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring-counter checker.
//   ring_state_e : lock FSM state encoding
//   rotl1        : rotate a RING_W-bit vector left by one (MSB wraps to bit 0)
//   is_onehot    : true when exactly one bit of a RING_W-bit vector is set
package ring_pkg;

  localparam int unsigned RING_W = 4;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } ring_state_e;

  function automatic logic [RING_W-1:0] rotl1(input logic [RING_W-1:0] v);
    return {v[RING_W-2:0], v[RING_W-1]};
  endfunction

  function automatic logic is_onehot(input logic [RING_W-1:0] v);
    return (v != '0) && ((v & (v - RING_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/ring_onehot_dec.sv
// Combinational one-hot decoder.
//   q       : input bus
//   valid_c : exactly one bit of q is set
//   idx_c   : binary position of the set bit (OR of set-bit indices, so no
//             priority chain; meaningful only when valid_c is high)
module ring_onehot_dec #(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned IW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] q,
  output logic             valid_c,
  output logic [IW-1:0]    idx_c
);

  logic [IW:0] ones;

  // Population count and index OR-reduction in one pass.
  always_comb begin
    ones  = '0;
    idx_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (q[i]) begin
        ones  = ones + (IW+1)'(1);
        idx_c = idx_c | IW'(i);
      end
    end
    valid_c = (ones == (IW+1)'(1));
  end

endmodule

// File: rtl/ring_seq_checker.sv
// Ring-counter sequence checker and decoder.
//   clk, rst  : clock, asynchronous active-low reset
//   en        : sample qualifier for q_in
//   q_in      : ring-counter bus under check
//   idx       : position of the set bit in the last valid sample
//   onehot_ok : last sample had exactly one bit set
//   locked    : LOCK_CNT consecutive legal rotations seen
//   seq_err   : pulse on a sequence error while locked
//   err_cnt   : saturating error count
//   lap_pulse : pulse on each MSB->bit0 wrap while locked
//   lap_cnt   : wrapping lap count
module ring_seq_checker
  import ring_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned ERR_W    = 8,
  parameter int unsigned LAP_W    = 8,
  localparam int unsigned IW      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] q_in,
  output logic [IW-1:0]    idx,
  output logic             onehot_ok,
  output logic             locked,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             lap_pulse,
  output logic [LAP_W-1:0] lap_cnt
);

  localparam int unsigned RUN_W = $clog2(LOCK_CNT + 1);

  ring_state_e      state;
  logic [RUN_W-1:0] run_cnt;
  logic             have_ref;
  logic [WIDTH-1:0] prev;

  logic             dec_valid;
  logic [IW-1:0]    dec_idx;
  logic [WIDTH-1:0] prev_rot;
  logic             legal;
  logic             wrap;

  ring_onehot_dec #(.WIDTH(WIDTH)) u_dec (
    .q       (q_in),
    .valid_c (dec_valid),
    .idx_c   (dec_idx)
  );

  // A legal step needs a reference and an exact left rotation of it; a
  // repeat never matches because a one-hot value differs from its rotation.
  assign prev_rot = {prev[WIDTH-2:0], prev[WIDTH-1]};
  assign legal    = have_ref & dec_valid & (q_in == prev_rot);
  assign wrap     = legal & prev[WIDTH-1];

  // locked is a direct decode of the state flop.
  assign locked = (state == LOCKED);

  // Lock FSM, reference tracking, counters and pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= HUNT;
      run_cnt   <= '0;
      have_ref  <= 1'b0;
      prev      <= '0;
      idx       <= '0;
      onehot_ok <= 1'b0;
      seq_err   <= 1'b0;
      err_cnt   <= '0;
      lap_pulse <= 1'b0;
      lap_cnt   <= '0;
    end else begin
      seq_err   <= 1'b0;
      lap_pulse <= 1'b0;
      if (en) begin
        onehot_ok <= dec_valid;
        if (dec_valid) begin
          prev     <= q_in;
          have_ref <= 1'b1;
          idx      <= dec_idx;
        end else begin
          have_ref <= 1'b0;
        end

        case (state)
          HUNT: begin
            if (legal) begin
              if (run_cnt == RUN_W'(LOCK_CNT - 1)) begin
                state   <= LOCKED;
                run_cnt <= '0;
              end else begin
                run_cnt <= run_cnt + RUN_W'(1);
              end
            end else begin
              run_cnt <= '0;
            end
          end
          LOCKED: begin
            if (legal) begin
              if (wrap) begin
                lap_pulse <= 1'b1;
                lap_cnt   <= lap_cnt + LAP_W'(1);
              end
            end else begin
              seq_err <= 1'b1;
              if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
              state   <= HUNT;
              run_cnt <= '0;
            end
          end
          default: begin
            state   <= HUNT;
            run_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ring_seq_checker.sv
// Self-checking bench for ring_seq_checker: a default-parameter instance and a
// narrow-counter instance share one stimulus stream and one reference model.
module tb_ring_seq_checker;

  localparam int unsigned W    = 4;
  localparam int unsigned LOCK = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] q_in;

  logic [1:0] idx_a, idx_b;
  logic       ok_a, ok_b, lk_a, lk_b, se_a, se_b, lp_a, lp_b;
  logic [7:0] err_a, lap_a;
  logic [1:0] err_b, lap_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ring_seq_checker u_big (
    .clk(clk), .rst(rst), .en(en), .q_in(q_in),
    .idx(idx_a), .onehot_ok(ok_a), .locked(lk_a), .seq_err(se_a),
    .err_cnt(err_a), .lap_pulse(lp_a), .lap_cnt(lap_a)
  );

  ring_seq_checker #(.ERR_W(2), .LAP_W(2)) u_small (
    .clk(clk), .rst(rst), .en(en), .q_in(q_in),
    .idx(idx_b), .onehot_ok(ok_b), .locked(lk_b), .seq_err(se_b),
    .err_cnt(err_b), .lap_pulse(lp_b), .lap_cnt(lap_b)
  );

  // Reference model: positions as integers, counts unbounded.
  bit m_have_ref, m_locked, m_ok, m_seq_err, m_lap_pulse;
  int m_prev_pos, m_run, m_err, m_lap, m_idx;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_have_ref = 0; m_locked = 0; m_ok = 0; m_seq_err = 0; m_lap_pulse = 0;
    m_prev_pos = 0; m_run = 0; m_err = 0; m_lap = 0; m_idx = 0;
  endtask

  task automatic model_step(input bit e, input logic [3:0] q);
    int  pos;
    bit  valid, legal;
    m_seq_err   = 0;
    m_lap_pulse = 0;
    if (!e) return;
    pos = 0;
    for (int i = 0; i < 4; i++) if (q[i]) pos = i;
    valid = ($countones(q) == 1);
    legal = m_have_ref && valid && (pos == (m_prev_pos + 1) % W);
    if (m_locked) begin
      if (legal) begin
        if (pos == 0) begin m_lap++; m_lap_pulse = 1; end
      end else begin
        m_err++; m_seq_err = 1; m_locked = 0; m_run = 0;
      end
    end else if (legal) begin
      m_run++;
      if (m_run == LOCK) begin m_locked = 1; m_run = 0; end
    end else begin
      m_run = 0;
    end
    m_ok = valid;
    if (valid) begin m_have_ref = 1; m_prev_pos = pos; m_idx = pos; end
    else m_have_ref = 0;
  endtask

  task automatic check_all();
    chk("idx_a", idx_a, m_idx);        chk("idx_b", idx_b, m_idx);
    chk("ok_a", ok_a, m_ok);           chk("ok_b", ok_b, m_ok);
    chk("locked_a", lk_a, m_locked);   chk("locked_b", lk_b, m_locked);
    chk("seq_err_a", se_a, m_seq_err); chk("seq_err_b", se_b, m_seq_err);
    chk("lap_pulse_a", lp_a, m_lap_pulse); chk("lap_pulse_b", lp_b, m_lap_pulse);
    chk("err_cnt_a", err_a, sat(m_err, 255)); chk("err_cnt_b", err_b, sat(m_err, 3));
    chk("lap_cnt_a", lap_a, m_lap % 256);     chk("lap_cnt_b", lap_b, m_lap % 4);
  endtask

  task automatic cycle(input bit e, input logic [3:0] q);
    en   = e;
    q_in = q;
    @(posedge clk);
    model_step(e, q);
    #1;
    check_all();
  endtask

  function automatic logic [3:0] next_legal();
    logic [3:0] one = 4'b0001;
    if (!m_have_ref) return one;
    return one << ((m_prev_pos + 1) % W);
  endfunction

  task automatic feed_ring(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, next_legal());
  endtask

  task automatic do_reset();
    en = 1'b0; q_in = '0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic relock();
    int guard = 0;
    while (!m_locked && guard < 20) begin
      cycle(1'b1, next_legal());
      guard++;
    end
    chk("relock", lk_a, 1);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; q_in = '0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // 1: clean ring from 0001; lock after fourth sample, two laps in 12
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, next_legal());
      if (i == 2) chk("not_yet_locked", lk_a, 0);
      if (i == 3) chk("locked_at_4", lk_a, 1);
    end
    chk("t1_laps", lap_a, 2);
    chk("t1_errs", err_a, 0);

    // 2: multi-hot injection, then resume from 0001
    cycle(1'b1, 4'b0110);
    chk("t2_seq_err", se_a, 1);
    chk("t2_ok", ok_a, 0);
    chk("t2_idx_held", idx_a, 3);
    relock();

    // 3: skipped step
    while (m_prev_pos != 0) cycle(1'b1, next_legal());
    cycle(1'b1, 4'b0100);
    chk("t3_skip_err", se_a, 1);
    cycle(1'b1, 4'b1000);
    chk("t3_no_err", se_a, 0);
    relock();

    // 4: repeat, then en=0 hold with random bus
    while (m_prev_pos != 0) cycle(1'b1, next_legal());
    cycle(1'b1, 4'b0010);
    cycle(1'b1, 4'b0010);
    chk("t4_repeat_err", se_a, 1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 4'($urandom));

    // 5: error saturation and lap wrap on the narrow instance
    do_reset();
    for (int k = 0; k < 5; k++) begin
      relock();
      cycle(1'b1, 4'b0000);
    end
    chk("t5_err_sat_b", err_b, 3);
    chk("t5_err_a", err_a, 5);
    do_reset();
    feed_ring(LOCK + 1 + 20);
    chk("t5_lap_wrap_b", lap_b, 1);
    chk("t5_lap_a", lap_a, 5);

    // 6: async reset between edges while locked with three laps
    do_reset();
    feed_ring(16);
    chk("t6_lap3", lap_a, 3);
    chk("t6_locked", lk_a, 1);
    do_reset();
    feed_ring(LOCK + 1);
    chk("t6_relock", lk_a, 1);

    // Randomized mix of legal steps, skips, repeats, invalids and idle cycles
    for (int i = 0; i < 2000; i++) begin
      int unsigned r = $urandom_range(99);
      logic [3:0] q;
      logic [3:0] one = 4'b0001;
      if (r < 70)      q = next_legal();
      else if (r < 78) q = one << m_prev_pos;
      else if (r < 86) q = one << $urandom_range(3);
      else             q = 4'($urandom);
      cycle(($urandom_range(9) != 0), q);
      if ($urandom_range(499) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ring_seq_checker.md
Name: ring_seq_checker

Overview:
Receive-side companion to the ring counter: it samples a ring-counter output bus and checks that it is a legal rotating one-hot sequence. It decodes the active bit position to a binary index and locks after a run of correct steps. It flags and counts sequence errors and counts completed laps. It sits downstream of any ring_cnt instance as an on-chip monitor and decoder.

Parameters:
- WIDTH, 4, ring width in bits (≥2).
- LOCK_CNT, 3, consecutive correct transitions required to enter LOCKED (≥1).
- ERR_W, 8, width of the saturating error counter.
- LAP_W, 8, width of the wrapping lap counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  sample qualifier; q_in is evaluated only on cycles with en=1.
- q_in  input  WIDTH  ring-counter bus under check.
- idx  output  $clog2(WIDTH)  binary position of the set bit in the last valid one-hot sample.
- onehot_ok  output  1  last sampled q_in had exactly one bit set.
- locked  output  1  FSM is in LOCKED.
- seq_err  output  1  one-cycle pulse on a detected error while LOCKED.
- err_cnt  output  ERR_W  total errors, saturates at all-ones.
- lap_pulse  output  1  one-cycle pulse on each MSB→bit0 wrap while LOCKED.
- lap_cnt  output  LAP_W  completed laps, wraps modulo 2^LAP_W.

Behaviour:
- Reset (rst=0, asynchronous), all outputs and state go to 0:
  - idx=0, onehot_ok=0, locked=0, seq_err=0, err_cnt=0, lap_pulse=0, lap_cnt=0.
  - FSM=HUNT, good-run counter=0, have_ref=0, prev=0.
- All outputs are registered. Sample with en=1 at edge N → outputs reflect it after edge N (1-cycle latency). en=0 holds all state; pulses drop to 0.
- Legal step: the current sample equals prev rotated left by one: bit i→i+1, bit WIDTH-1→bit 0. Example for WIDTH=4: 0001→0010→0100→1000→0001.
- Valid sample: exactly one bit set. All-zero and multi-hot samples are invalid.
- Repeat: a sample equal to prev is not a legal step.
- have_ref / prev handling:
  - A valid sample when have_ref=0 loads prev, sets have_ref=1, updates idx, and gives no error.
  - An invalid sample clears have_ref.
  - Every valid sample loads prev and idx.
  - idx holds its value on invalid samples.
- FSM states HUNT and LOCKED:
  - HUNT, legal step: good-run counter +1. When it reaches LOCK_CNT → LOCKED and the counter clears.
  - HUNT, illegal step or invalid sample: counter clears. No seq_err and no err_cnt change.
  - LOCKED, legal step: stay in LOCKED. If the step is WIDTH-1→0, lap_pulse=1 and lap_cnt+1 (wrapping).
  - LOCKED, illegal step, repeat, or invalid sample: seq_err=1, err_cnt+1 (saturating), go to HUNT, counter clears.
- The step that completes lock does not count a lap, even if it is a wrap. Laps are counted only when already in LOCKED.
- Error and lap cannot coincide, because a wrap is by definition a legal step.
- Reset mid-operation: immediate clear. Re-acquisition starts from the have_ref=0 condition.

Decomposition:
- Package ring_pkg holds:
  - typedef enum logic {HUNT, LOCKED} ring_state_e;
  - function rotl1(logic [WIDTH-1:0]) (parameterized via a localparam default of 4; modules cast as needed);
  - function is_onehot.
- One sub-module, ring_onehot_dec: combinational WIDTH→{valid, idx} priority-free decoder, reusable elsewhere.
- The FSM, counters, and output registers live in ring_seq_checker.

Test Plan:
1. Reset, then drive a ring counter (0001 start, en=1 every cycle) for 12 cycles → locked=1 after the third step (cycle 4 sample). lap_pulse fires on each later 1000→0001. After 12 samples lap_cnt=2, err_cnt=0, and idx follows 0,1,2,3.
2. Once locked, inject 0110 for one cycle, then resume 0001… → seq_err pulse once, err_cnt=1, locked=0, onehot_ok=0, idx held. Relock after LOCK_CNT legal steps following the first valid sample.
3. Once locked, inject a skipped step 0001→0100 → seq_err=1, err_cnt=1, locked=0. 0100 becomes the new reference. Next 1000 counts as good-run 1.
4. Once locked, inject a repeat 0010,0010 → error counted. Then hold en=0 for 5 cycles with random q_in → no state change, no pulses.
5. ERR_W=2, generate 5 errors, each preceded by relock → err_cnt saturates at 3. LAP_W=2, run 5 laps → lap_cnt=1.
6. Assert rst low asynchronously between edges while locked with lap_cnt=3 → all outputs 0 immediately. Release, then apply legal stream → first lock after LOCK_CNT steps.
